btc_job_loader: RTL and testbench

Upstream job feeder for the mining core. Accepts an 80-byte block header as a stream of twenty 32-bit words with a valid/ready handshake and assembles it in a shadow buffer. When the header is complete and the core reports `done`, it copies the buffer into the active header registers that drive the core and issues a one-cycle `start`. The next job can be loaded while the current one is mining (double buffering).

---
 rtl/btc_job_loader.sv | 183 ++++++++++++++++++
 tb/tb_btc_job_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btc_job_loader.sv
// ----------------------------------------------------------------------------
// btc_job_loader
//
// Upstream job feeder for the mining core. Collects a 20-word (80-byte) block
// header into a shadow buffer over a valid/ready stream, then copies it into
// the active header registers and pulses start once the core is idle. A new
// header can be streamed in while the current one is being mined.
//
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   header word stream, s_last marks word 19
//   abort                    discard the shadow header (active job untouched)
//   core_done                core idle flag
//   start                    one-cycle start pulse to the core
//   version .. nonce_in      active header words 0..19
//   job_pending              shadow buffer holds a complete header
//   frame_err                one-cycle pulse after a header is dropped
//   jobs_launched            wrapping count of start pulses
// ----------------------------------------------------------------------------
module btc_job_loader #(
    parameter int unsigned JOB_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    input  logic                 s_last,
    input  logic                 abort,
    input  logic                 core_done,
    output logic                 start,
    output logic [31:0]          version,
    output logic [31:0]          previous_hash_0,
    output logic [31:0]          previous_hash_1,
    output logic [31:0]          previous_hash_2,
    output logic [31:0]          previous_hash_3,
    output logic [31:0]          previous_hash_4,
    output logic [31:0]          previous_hash_5,
    output logic [31:0]          previous_hash_6,
    output logic [31:0]          previous_hash_7,
    output logic [31:0]          merkle_root_0,
    output logic [31:0]          merkle_root_1,
    output logic [31:0]          merkle_root_2,
    output logic [31:0]          merkle_root_3,
    output logic [31:0]          merkle_root_4,
    output logic [31:0]          merkle_root_5,
    output logic [31:0]          merkle_root_6,
    output logic [31:0]          merkle_root_7,
    output logic [31:0]          btime,
    output logic [31:0]          bits,
    output logic [31:0]          nonce_in,
    output logic                 job_pending,
    output logic                 frame_err,
    output logic [JOB_CNT_W-1:0] jobs_launched
);

    localparam int unsigned NumWords = 20;

    typedef enum logic [1:0] {
        LIdle,
        LStart,
        LWait
    } lstate_e;

    lstate_e state_q, state_d;

    logic [4:0]  wcnt_q, wcnt_d;
    logic [31:0] shadow_q [NumWords];
    logic [31:0] active_q [NumWords];
    logic        frame_err_q, frame_err_d;
    logic [JOB_CNT_W-1:0] jobs_q;

    logic accept;
    logic frame_bad;
    logic copy;

    assign job_pending = (wcnt_q == 5'd20);
    assign s_ready     = !job_pending && !abort;
    assign accept      = s_valid && s_ready;
    // s_last must be set on exactly the word landing at index 19.
    assign frame_bad   = (s_last != (wcnt_q == 5'd19));

    // Launch FSM
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        unique case (state_q)
            LIdle: begin
                if (job_pending && core_done) begin
                    copy    = 1'b1;
                    state_d = LStart;
                end
            end
            LStart: state_d = LWait;
            // Wait for the core to drop its stale done before re-arming.
            LWait: begin
                if (!core_done) begin
                    state_d = LIdle;
                end
            end
            default: state_d = LIdle;
        endcase
    end

    // Fill counter; a copy consumes the shadow and takes priority over abort.
    always_comb begin
        wcnt_d      = wcnt_q;
        frame_err_d = 1'b0;
        if (copy || abort) begin
            wcnt_d = 5'd0;
        end else if (accept) begin
            if (frame_bad) begin
                wcnt_d      = 5'd0;
                frame_err_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= LIdle;
            wcnt_q      <= 5'd0;
            frame_err_q <= 1'b0;
            jobs_q      <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            frame_err_q <= frame_err_d;
            if (state_q == LStart) begin
                jobs_q <= jobs_q + JOB_CNT_W'(1);
            end
        end
    end

    // Shadow contents are only meaningful below wcnt, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumWords; i++) begin
            if (accept && (wcnt_q == 5'(i))) begin
                shadow_q[i] <= s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NumWords; i++) begin
                active_q[i] <= 32'd0;
            end
        end else if (copy) begin
            for (int i = 0; i < NumWords; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    assign start         = (state_q == LStart);
    assign frame_err     = frame_err_q;
    assign jobs_launched = jobs_q;

    assign version         = active_q[0];
    assign previous_hash_0 = active_q[1];
    assign previous_hash_1 = active_q[2];
    assign previous_hash_2 = active_q[3];
    assign previous_hash_3 = active_q[4];
    assign previous_hash_4 = active_q[5];
    assign previous_hash_5 = active_q[6];
    assign previous_hash_6 = active_q[7];
    assign previous_hash_7 = active_q[8];
    assign merkle_root_0   = active_q[9];
    assign merkle_root_1   = active_q[10];
    assign merkle_root_2   = active_q[11];
    assign merkle_root_3   = active_q[12];
    assign merkle_root_4   = active_q[13];
    assign merkle_root_5   = active_q[14];
    assign merkle_root_6   = active_q[15];
    assign merkle_root_7   = active_q[16];
    assign btime           = active_q[17];
    assign bits            = active_q[18];
    assign nonce_in        = active_q[19];

endmodule

// File: tb/tb_btc_job_loader.sv
module tb_btc_job_loader;

    localparam int unsigned CW = 4;

    typedef logic [19:0][31:0] hdr_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          abort = 1'b0;
    logic          core_done;
    logic [31:0]   s_data = 32'd0;
    logic          s_ready, start, job_pending, frame_err;
    logic [CW-1:0] jobs_launched;
    logic [31:0]   version, btime, bits, nonce_in;
    logic [31:0]   ph0, ph1, ph2, ph3, ph4, ph5, ph6, ph7;
    logic [31:0]   mr0, mr1, mr2, mr3, mr4, mr5, mr6, mr7;
    hdr_t          act_hdr;

    assign act_hdr = {nonce_in, bits, btime, mr7, mr6, mr5, mr4, mr3, mr2, mr1, mr0,
                      ph7, ph6, ph5, ph4, ph3, ph2, ph1, ph0, version};

    btc_job_loader #(.JOB_CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .abort(abort), .core_done(core_done),
        .start(start), .version(version),
        .previous_hash_0(ph0), .previous_hash_1(ph1), .previous_hash_2(ph2),
        .previous_hash_3(ph3), .previous_hash_4(ph4), .previous_hash_5(ph5),
        .previous_hash_6(ph6), .previous_hash_7(ph7),
        .merkle_root_0(mr0), .merkle_root_1(mr1), .merkle_root_2(mr2),
        .merkle_root_3(mr3), .merkle_root_4(mr4), .merkle_root_5(mr5),
        .merkle_root_6(mr6), .merkle_root_7(mr7),
        .btime(btime), .bits(bits), .nonce_in(nonce_in),
        .job_pending(job_pending), .frame_err(frame_err), .jobs_launched(jobs_launched)
    );

    always #5 clk = ~clk;

    // Reference model state: complete headers in arrival order, the header the
    // core should currently see, and event counts.
    hdr_t exp_q[$];
    hdr_t cur = '0;
    int   exp_launch = 0;
    int   exp_ferr = 0;
    int   seen_ferr = 0;
    int   core_busy = 5;
    int   gapmax = 0;
    logic prev_start = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic chk_hdr(input string name, input hdr_t got, input hdr_t want);
        total++;
        if (got !== want) begin
            bad++;
            for (int i = 0; i < 20; i++) begin
                if (got[i] !== want[i]) begin
                    $display("FAIL %s: word %0d got=%h want=%h t=%0t",
                             name, i, got[i], want[i], $time);
                    break;
                end
            end
        end
    endtask

    // Simple core: drops done the cycle after start, stays busy, raises done.
    initial begin
        core_done = 1'b1;
        forever begin
            @(negedge clk);
            if (arst_n && start) begin
                @(posedge clk);
                #1 core_done = 1'b0;
                repeat (core_busy) @(posedge clk);
                #1 core_done = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (arst_n) begin
            if (start) begin
                chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
                chk("start_width", 32'(prev_start), 32'd0);
                chk("jobs_launched", 32'(jobs_launched), 32'(exp_launch % (1 << CW)));
                chk("pending_after_copy", 32'(job_pending), 32'd0);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                exp_launch++;
            end
            chk_hdr("active_regs", act_hdr, cur);
            if (frame_err) seen_ferr++;
            prev_start = start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        while (!s_ready && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 5000) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // bad_at < 0: well-formed; 0..18: s_last early; 19: s_last missing
    task automatic send_hdr(input hdr_t h, input int bad_at);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
            if (bad_at < 0) send_word(h[i], i == 19);
            else if (bad_at == 19) send_word(h[i], 1'b0);
            else send_word(h[i], i == bad_at);
            if (bad_at == i) break;
        end
        if (bad_at < 0) exp_q.push_back(h);
        else exp_ferr++;
    endtask

    task automatic send_abort(input int k);
        for (int i = 0; i < k; i++) send_word($urandom, 1'b0);
        @(negedge clk);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hdead_beef;
        #1;
        chk("ready_during_abort", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        abort   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !core_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur        = '0;
        exp_launch = 0;
        exp_ferr   = 0;
        seen_ferr  = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk_hdr({tag, "_active"}, act_hdr, '0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_jobs"}, 32'(jobs_launched), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_pending"}, 32'(job_pending), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        model_clear();
        chk("reset_start_low", 32'(start), 32'd0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        #1;
        check_reset_state("post_reset");
    endtask

    function automatic hdr_t rand_hdr();
        hdr_t h;
        for (int i = 0; i < 20; i++) h[i] = $urandom;
        return h;
    endfunction

    initial begin
        hdr_t h;
        int   n;
        int   kind;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        arst_n = 1'b1;

        // Single launch with an incrementing header
        for (int i = 0; i < 20; i++) h[i] = 32'h100 + 32'(i);
        send_hdr(h, -1);
        wait_idle();
        chk("single_version", version, 32'h100);
        chk("single_nonce", nonce_in, 32'h113);
        chk("single_jobs", 32'(jobs_launched), 32'd1);

        // Framing errors, each followed by a good header
        send_hdr(rand_hdr(), 5);
        repeat (3) @(negedge clk);
        chk("ferr_early_last", 32'(seen_ferr), 32'(exp_ferr));
        chk("ferr_pending", 32'(job_pending), 32'd0);
        send_hdr(rand_hdr(), -1);
        wait_idle();
        send_hdr(rand_hdr(), 19);
        send_hdr(rand_hdr(), -1);
        wait_idle();
        chk("ferr_missing_last", 32'(seen_ferr), 32'(exp_ferr));

        // Abort after 10 words, then a clean header
        send_abort(10);
        send_hdr(rand_hdr(), -1);
        wait_idle();

        // Double buffering: B loads while A mines; C copy collides with abort
        core_busy = 100;
        send_hdr(rand_hdr(), -1);
        send_hdr(rand_hdr(), -1);
        @(negedge clk);
        chk("dbuf_pending", 32'(job_pending), 32'd1);
        chk("dbuf_ready", 32'(s_ready), 32'd0);
        chk("dbuf_no_start", 32'(exp_q.size()), 32'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("dbuf_b_launched", 32'(exp_q.size()), 32'd0);
        send_hdr(rand_hdr(), -1);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!core_done && n < 1000);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("copy_beats_abort_pending", 32'(job_pending), 32'd0);
        core_busy = 5;
        wait_idle();

        // Reset with a partial header (12 words) loaded
        for (int i = 0; i < 12; i++) send_word($urandom, 1'b0);
        do_reset();
        send_hdr(rand_hdr(), -1);
        wait_idle();

        // Reset while start is in flight
        send_hdr(rand_hdr(), -1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!start && n < 200);
        chk("lstart_reached", 32'(start), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("lstart_reset_kills_start", 32'(start), 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        #1;
        check_reset_state("lstart_reset");
        repeat (30) @(negedge clk);
        chk("lstart_reset_no_launch", 32'(jobs_launched), 32'd0);

        // Randomized traffic; enough launches to wrap the counter
        for (int it = 0; it < 45; it++) begin
            core_busy = $urandom_range(1, 40);
            gapmax    = $urandom_range(0, 2);
            kind      = $urandom_range(0, 9);
            if (kind == 0) send_hdr(rand_hdr(), $urandom_range(0, 19));
            else if (kind == 1) send_abort($urandom_range(1, 19));
            else send_hdr(rand_hdr(), -1);
        end
        wait_idle();
        chk("final_frame_err_count", 32'(seen_ferr), 32'(exp_ferr));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_jobs", 32'(jobs_launched), 32'(exp_launch % (1 << CW)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
